// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM encodings and port indices.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACCESS = 2'b01,
      S_RESP   = 2'b10
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way winner selector: round-robin against last_grant, or fixed
// priority to port 0 when rr is low.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   input  logic rr,
   output logic winner
);

   // A tie goes to the port that did not win last time, unless priority is fixed.
   always_comb begin
      winner = PORT_CPU;
      if (req0 && req1) begin
         if (rr) begin
            winner = ~last_grant;
         end else begin
            winner = PORT_CPU;
         end
      end else if (req1) begin
         winner = PORT_DMA;
      end else begin
         winner = PORT_CPU;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the unified CPU instruction/data memory. One transfer
// at a time: grant in IDLE, MEM_LAT access cycles, then a one-cycle ack.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned MEM_LAT = 1,
   parameter int unsigned RR      = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          we_q, we_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          last_grant_q, last_grant_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          busy_q, busy_d;
   logic          winner_s;
   logic          rr_s;

   assign rr_s = (RR != 0);

   rr_pick2 u_pick (
      .req0       (req0),
      .req1       (req1),
      .last_grant (last_grant_q),
      .rr         (rr_s),
      .winner     (winner_s)
   );

   // Next-state logic; outputs are derived from the next state so they can be registered.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      we_d         = we_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;

      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               state_d = S_ACCESS;
               owner_d = winner_s;
               cnt_d   = CNT_INIT;
               if (winner_s == PORT_DMA) begin
                  we_d        = we1;
                  mem_addr_d  = addr1;
                  mem_wdata_d = wdata1;
               end else begin
                  we_d        = we0;
                  mem_addr_d  = addr0;
                  mem_wdata_d = wdata0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               // Read data is only valid in the last access cycle; writes leave rdata alone.
               if (!we_q && (owner_q == PORT_DMA)) begin
                  rdata1_d = mem_rdata;
               end else if (!we_q) begin
                  rdata0_d = mem_rdata;
               end else begin
                  rdata0_d = rdata0_q;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            last_grant_d = owner_q;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      mem_en_d = (state_d == S_ACCESS);
      mem_we_d = mem_en_d & we_d;
      ack0_d   = (state_d == S_RESP) && (owner_d == PORT_CPU);
      ack1_d   = (state_d == S_RESP) && (owner_d == PORT_DMA);
      busy_d   = (state_d == S_ACCESS) || (state_d == S_RESP);
   end

   // State and registered outputs; an asynchronous reset aborts any transfer in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         owner_q      <= PORT_CPU;
         we_q         <= 1'b0;
         cnt_q        <= 4'd0;
         last_grant_q <= PORT_DMA;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= {DW{1'b0}};
         rdata1_q     <= {DW{1'b0}};
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= {AW{1'b0}};
         mem_wdata_q  <= {DW{1'b0}};
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         busy_q       <= busy_d;
      end
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule
